// File: rtl/heat_column_responder.sv
// Column end of the col_select/return_sig point-write handshake plus a dual-port heat store. Optional accumulate mode: HEAT_ACCUM_EN.
// return_sig from N+2 (N+4 accumulating); the writer is held off until release; no requests are taken while a clear sweep runs.
module heat_column_responder #(
    parameter int ROWS   = 480,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_col_select,
    input  logic [9:0]               i_row_select,
    input  logic signed [DATA_W-1:0] i_val_in,
    output logic                     o_return_sig,
    input  logic                     i_clear_req,
    output logic                     o_busy,
    output logic                     o_row_err,
    input  logic [ADDR_W-1:0]        i_vga_row,
    output logic signed [DATA_W-1:0] o_vga_data
);
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_ACK, S_RELEASE, S_CLEAR, S_RD, S_RD_WAIT, S_MODIFY
    } state_t;

    localparam logic [9:0]        ROWS_L    = 10'(ROWS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS - 1);

    state_t                   r_state, w_next;
    logic [ADDR_W-1:0]        r_row, r_clr_addr, r_vga_addr;
    logic signed [DATA_W-1:0] r_val, r_vga_data;
    logic                     r_row_oob, r_row_err;
    logic signed [DATA_W-1:0] r_mem [0:ROWS-1];

    logic                     w_accept, w_req_oob, w_we, w_set_err;
    logic [ADDR_W-1:0]        w_waddr;
    logic signed [DATA_W-1:0] w_wdata;

    assign w_req_oob = (i_row_select >= ROWS_L);
    assign w_accept  = (r_state == S_IDLE) && !i_clear_req && i_col_select;

`ifdef HEAT_ACCUM_EN
    logic [ADDR_W-1:0]        r_a_addr;
    logic signed [DATA_W-1:0] r_a_q;
    logic [DATA_W:0]          w_sum;
    logic signed [DATA_W-1:0] w_sat;

    // Port-A read path mirrors port B: registered address, registered data.
    always_ff @(posedge i_clock) begin
        r_a_addr <= r_row;
        r_a_q    <= r_mem[r_a_addr];
    end

    assign w_sum = {r_a_q[DATA_W-1], r_a_q} + {r_val[DATA_W-1], r_val};

    always_comb begin
        w_sat = w_sum[DATA_W-1:0];
        if (w_sum[DATA_W] != w_sum[DATA_W-1])
            w_sat = w_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end

    assign w_set_err = w_accept && w_req_oob;
`else
    assign w_set_err = (r_state == S_WRITE) && r_row_oob;
`endif

    always_comb begin
        w_next  = r_state;
        w_we    = 1'b0;
        w_waddr = r_row;
        w_wdata = r_val;
        case (r_state)
            S_IDLE: begin
                if (i_clear_req)
                    w_next = S_CLEAR;
                else if (i_col_select)
`ifdef HEAT_ACCUM_EN
                    w_next = w_req_oob ? S_ACK : S_RD;
`else
                    w_next = S_WRITE;
`endif
            end
            S_WRITE: begin
                w_we   = !r_row_oob;
                w_next = S_ACK;
            end
            S_ACK:     w_next = S_RELEASE;
            S_RELEASE: if (!i_col_select) w_next = S_IDLE;
            S_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_addr;
                w_wdata = '0;
                if (r_clr_addr == LAST_ADDR) w_next = S_IDLE;
            end
`ifdef HEAT_ACCUM_EN
            S_RD:      w_next = S_RD_WAIT;
            S_RD_WAIT: w_next = S_MODIFY;
            S_MODIFY: begin
                w_we    = !r_row_oob;
                w_wdata = w_sat;
                w_next  = S_ACK;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_row_err  <= 1'b0;
            r_vga_data <= '0;
            r_clr_addr <= '0;
            r_row      <= '0;
            r_val      <= '0;
            r_row_oob  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_vga_data <= r_mem[r_vga_addr];
            r_clr_addr <= (r_state == S_CLEAR) ? r_clr_addr + 1'b1 : '0;
            if (w_set_err) r_row_err <= 1'b1;
            if (w_accept) begin
                r_row     <= i_row_select[ADDR_W-1:0];
                r_val     <= i_val_in;
                r_row_oob <= w_req_oob;
            end
        end
    end

    // Storage is never reset so a reset mid-operation keeps what was already written.
    always_ff @(posedge i_clock) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
        r_vga_addr <= i_vga_row;
    end

    assign o_return_sig = (r_state == S_ACK) || (r_state == S_RELEASE);
    assign o_busy       = (r_state == S_CLEAR);
    assign o_row_err    = r_row_err;
    assign o_vga_data   = r_vga_data;
endmodule

// File: tb/tb_heat_column_responder.sv
// Bench for heat_column_responder: directed vector table, hand sequences for multi-cycle corners, then random writes/reads.
module tb_heat_column_responder;
    localparam int ROWS = 480;
`ifdef HEAT_ACCUM_EN
    localparam int LAT_IN = 4;
    localparam int LAT_OOB = 1;
`else
    localparam int LAT_IN = 2;
    localparam int LAT_OOB = 2;
`endif

    logic              clk = 1'b0;
    logic              reset, col_select, clear_req, return_sig, busy, row_err;
    logic [9:0]        row_select;
    logic signed [7:0] val_in, vga_data;
    logic [8:0]        vga_row;

    int n_vec = 0;
    int n_bad = 0;
    int model [ROWS];

    always #5 clk = ~clk;

    heat_column_responder dut (
        .i_clock(clk), .i_reset(reset), .i_col_select(col_select),
        .i_row_select(row_select), .i_val_in(val_in), .o_return_sig(return_sig),
        .i_clear_req(clear_req), .o_busy(busy), .o_row_err(row_err),
        .i_vga_row(vga_row), .o_vga_data(vga_data)
    );

    typedef struct {
        int row;
        int val;
        int exp_err;
    } wvec_t;

    function automatic int upd(int old_v, int v);
`ifdef HEAT_ACCUM_EN
        int s;
        s = old_v + v;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
`else
        return v;
`endif
    endfunction

    task automatic chk(string nm, int act, int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic do_write(int row, int val);
        int lat;
        col_select = 1'b1;
        row_select = row[9:0];
        val_in     = val[7:0];
        lat        = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (return_sig) begin
                lat = k;
                break;
            end
        end
        chk("ack_latency", lat, (row < ROWS) ? LAT_IN : LAT_OOB);
        @(negedge clk);
        chk("ack_hold", int'(return_sig), 1);
        col_select = 1'b0;
        @(negedge clk);
        chk("ack_release", int'(return_sig), 0);
        if (row < ROWS) model[row] = upd(model[row], val);
    endtask

    task automatic chk_row(int row);
        vga_row = row[8:0];
        @(negedge clk);
        @(negedge clk);
        chk("vga_read", int'(vga_data), model[row]);
    endtask

    task automatic do_clear();
        int cnt;
        int seen_ret;
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        cnt = 0;
        seen_ret = 0;
        while (busy && cnt < 2000) begin
            cnt++;
            if (return_sig) seen_ret = 1;
            clear_req = (cnt == 100);
            @(negedge clk);
        end
        clear_req = 1'b0;
        chk("busy_cycles", cnt, ROWS);
        chk("ret_during_clear", seen_ret, 0);
        for (int r = 0; r < ROWS; r++) model[r] = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wvec_t tbl [12];
        int    lat;
        tbl = '{
            '{5, 37, 0}, '{0, -128, 0}, '{479, 127, 0}, '{239, -1, 0},
            '{5, -5, 0}, '{3, 100, 0}, '{3, 50, 0}, '{300, -128, 0},
            '{300, -128, 0}, '{480, 12, 1}, '{600, 99, 1}, '{1023, -7, 1}
        };

        reset = 1'b0; col_select = 1'b0; clear_req = 1'b0;
        row_select = '0; val_in = '0; vga_row = '0;
        repeat (3) @(negedge clk);
        chk("rst_return_sig", int'(return_sig), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_row_err", int'(row_err), 0);
        chk("rst_vga_data", int'(vga_data), 0);
        reset = 1'b1;
        @(negedge clk);

        do_clear();

        foreach (tbl[i]) begin
            do_write(tbl[i].row, tbl[i].val);
            chk("row_err", int'(row_err), tbl[i].exp_err);
        end
        foreach (tbl[i]) if (tbl[i].row < ROWS) chk_row(tbl[i].row);
        chk_row(88);
        chk_row(1);

        // Port B reading the row port A writes in the same cycle sees the old value.
        do_write(7, 20);
        vga_row = 9'd7;
        @(negedge clk);
        @(negedge clk);
        col_select = 1'b1; row_select = 10'd7; val_in = -8'sd30;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (return_sig) begin
                lat = k;
                break;
            end
        end
        chk("rw_latency", lat, LAT_IN);
        chk("rw_collision_old", int'(vga_data), 20);
        @(negedge clk);
        chk("rw_collision_new", int'(vga_data), upd(20, -30));
        col_select = 1'b0;
        @(negedge clk);
        model[7] = upd(20, -30);

        // Clear and request together: the sweep runs first, then the held request completes.
        col_select = 1'b1; row_select = 10'd10; val_in = 8'sd55;
        do_clear();
        do_write(10, 55);
        chk("row_err_sticky", int'(row_err), 1);
        chk_row(10);
        chk_row(5);
        chk_row(479);

        // Reset while acknowledging: handshake abandoned, written data retained.
        col_select = 1'b1; row_select = 10'd20; val_in = 8'sd66;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (return_sig) begin
                lat = k;
                break;
            end
        end
        chk("ack_before_reset", lat, LAT_IN);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ack_return_sig", int'(return_sig), 0);
        chk("rst_ack_row_err", int'(row_err), 0);
        chk("rst_ack_vga_data", int'(vga_data), 0);
        reset = 1'b1;
        col_select = 1'b0;
        model[20] = upd(0, 66);
        @(negedge clk);
        chk("after_rst_return_sig", int'(return_sig), 0);
        chk_row(20);
        do_write(21, 9);
        chk_row(21);

        // Reset mid-sweep: early rows already zeroed, late rows untouched.
        do_write(479, 77);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (50) @(negedge clk);
        chk("mid_clear_busy", int'(busy), 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_clear_rst_busy", int'(busy), 0);
        reset = 1'b1;
        model[0] = 0;
        chk_row(0);
        chk_row(479);
        do_clear();

        for (int i = 0; i < 30; i++)
            do_write($urandom_range(0, ROWS - 1), int'($urandom_range(0, 255)) - 128);
        for (int i = 0; i < 30; i++)
            chk_row($urandom_range(0, ROWS - 1));
        for (int i = 0; i < 4; i++) begin
            int r;
            r = $urandom_range(0, ROWS - 1);
            do_write(r, int'($urandom_range(0, 255)) - 128);
            chk_row(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
